// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scanner with settle-timed column sampling,
// whole-frame debounce, ghost (multi-key) rejection and a press/release FIFO.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   row_out           - row drive, one row low at a time (registered)
//   col_in            - column sense, active low (synchronised here)
//   key_down/key_code - stable single-key level and its code (row*COLS+col)
//   event_valid/event_press/event_code/event_ready - FWFT event FIFO head
//   overrun           - one-cycle pulse per event dropped on a full FIFO
module keypad_scanner #(
   parameter int unsigned ROWS       = 4,
   parameter int unsigned COLS       = 3,
   parameter int unsigned SCAN_DIV   = 1024,
   parameter int unsigned SETTLE     = 1008,
   parameter int unsigned DEBOUNCE   = 3,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned KW         = $clog2(ROWS*COLS)
) (
   input  logic            clk,
   input  logic            reset,
   output logic [ROWS-1:0] row_out,
   input  logic [COLS-1:0] col_in,
   output logic            key_down,
   output logic [KW-1:0]   key_code,
   output logic            event_valid,
   output logic            event_press,
   output logic [KW-1:0]   event_code,
   input  logic            event_ready,
   output logic            overrun
);

   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned SW = $clog2(SCAN_DIV);
   localparam int unsigned CW = $clog2(DEBOUNCE + 1);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic {IDLE, COUNT} state_e;

   logic [SW-1:0]   slot_q, slot_d;
   logic [RW-1:0]   row_q, row_d;
   logic [ROWS-1:0] row_out_q;
   logic [COLS-1:0] col_s1_q, col_s2_q;
   logic            sample_c;
   logic            eval_q;
   logic [1:0]      hits_q, hits_d;     // pressed count this frame, saturating at 2
   logic [KW-1:0]   hcode_q, hcode_d;   // code of the first pressed position

   state_e          state_q, state_d;
   logic            cand_key_q, cand_key_d;
   logic [KW-1:0]   cand_code_q, cand_code_d;
   logic [CW-1:0]   dcnt_q, dcnt_d;
   logic            stab_key_q, stab_key_d;
   logic [KW-1:0]   stab_code_q, stab_code_d;
   logic            pend_q, pend_d;     // press half of a key-to-key change
   logic [KW-1:0]   pend_code_q, pend_code_d;
   logic            push_c, push_press_c;
   logic [KW-1:0]   push_code_c;

   logic [KW-1:0]         code_mem_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] press_mem_q;
   logic [AW:0]           wr_q, rd_q;
   logic                  full_c, empty_c, pop_c, wr_en_c;
   logic                  overrun_q;

   // Slot/row sequencing and frame accumulation.
   always_comb begin
      slot_d   = slot_q + SW'(1);
      row_d    = row_q;
      hits_d   = hits_q;
      hcode_d  = hcode_q;
      sample_c = (slot_q == SW'(SETTLE));
      if (slot_q == SW'(SCAN_DIV - 1)) begin
         slot_d = '0;
         row_d  = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
      end
      if (eval_q) begin
         hits_d  = '0;
         hcode_d = '0;
      end
      if (sample_c) begin
         for (int c = 0; c < COLS; c++) begin
            if (!col_s2_q[c]) begin
               if (hits_d == 2'd0) hcode_d = KW'(row_q) * KW'(COLS) + KW'(c);
               if (hits_d != 2'd2) hits_d = hits_d + 2'd1;
            end
         end
      end
   end

   // Debounce FSM and event generation on frame evaluation.
   always_comb begin
      state_d      = state_q;
      cand_key_d   = cand_key_q;
      cand_code_d  = cand_code_q;
      dcnt_d       = dcnt_q;
      stab_key_d   = stab_key_q;
      stab_code_d  = stab_code_q;
      pend_d       = 1'b0;
      pend_code_d  = pend_code_q;
      push_c       = pend_q;
      push_press_c = 1'b1;
      push_code_c  = pend_code_q;
      if (eval_q) begin
         if (hits_q == 2'd2) begin
            state_d     = IDLE;
            cand_key_d  = 1'b0;
            cand_code_d = '0;
            dcnt_d      = '0;
         end else begin
            if (state_q == COUNT && cand_key_q == (hits_q == 2'd1) && cand_code_q == hcode_q) begin
               if (dcnt_q != CW'(DEBOUNCE)) dcnt_d = dcnt_q + CW'(1);
            end else begin
               state_d     = COUNT;
               cand_key_d  = (hits_q == 2'd1);
               cand_code_d = hcode_q;
               dcnt_d      = CW'(1);
            end
            if (dcnt_d == CW'(DEBOUNCE) &&
                (cand_key_d != stab_key_q || cand_code_d != stab_code_q)) begin
               stab_key_d  = cand_key_d;
               stab_code_d = cand_code_d;
               push_c      = 1'b1;
               if (stab_key_q) begin
                  push_press_c = 1'b0;
                  push_code_c  = stab_code_q;
                  pend_d       = cand_key_d;
                  pend_code_d  = cand_code_d;
               end else begin
                  push_code_c  = cand_code_d;
               end
            end
         end
      end
   end

   // FIFO control; a push at full only lands if the head leaves the same cycle.
   always_comb begin
      empty_c = (wr_q == rd_q);
      full_c  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      pop_c   = !empty_c && event_ready;
      wr_en_c = push_c && (!full_c || pop_c);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q      <= '0;
         row_q       <= '0;
         row_out_q   <= '1;
         col_s1_q    <= '1;
         col_s2_q    <= '1;
         eval_q      <= 1'b0;
         hits_q      <= '0;
         hcode_q     <= '0;
         state_q     <= IDLE;
         cand_key_q  <= 1'b0;
         cand_code_q <= '0;
         dcnt_q      <= '0;
         stab_key_q  <= 1'b0;
         stab_code_q <= '0;
         pend_q      <= 1'b0;
         pend_code_q <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         press_mem_q <= '0;
         overrun_q   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) code_mem_q[i] <= '0;
      end else begin
         slot_q      <= slot_d;
         row_q       <= row_d;
         row_out_q   <= ~(ROWS'(1) << row_d);
         col_s1_q    <= col_in;
         col_s2_q    <= col_s1_q;
         eval_q      <= sample_c && (row_q == RW'(ROWS - 1));
         hits_q      <= hits_d;
         hcode_q     <= hcode_d;
         state_q     <= state_d;
         cand_key_q  <= cand_key_d;
         cand_code_q <= cand_code_d;
         dcnt_q      <= dcnt_d;
         stab_key_q  <= stab_key_d;
         stab_code_q <= stab_code_d;
         pend_q      <= pend_d;
         pend_code_q <= pend_code_d;
         overrun_q   <= push_c && !wr_en_c;
         if (pop_c) rd_q <= rd_q + (AW+1)'(1);
         if (wr_en_c) begin
            code_mem_q[wr_q[AW-1:0]]  <= push_code_c;
            press_mem_q[wr_q[AW-1:0]] <= push_press_c;
            wr_q <= wr_q + (AW+1)'(1);
         end
      end
   end

   assign row_out     = row_out_q;
   assign key_down    = stab_key_q;
   assign key_code    = stab_code_q;
   assign overrun     = overrun_q;
   assign event_valid = !empty_c;
   assign event_press = empty_c ? 1'b0 : press_mem_q[rd_q[AW-1:0]];
   assign event_code  = empty_c ? '0 : code_mem_q[rd_q[AW-1:0]];

endmodule
